mult_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit for the MiniMIPS datapath, serving MULT, MULTU, DIV and DIVU. Operands come from the register-file read ports. Results are held in architectural HI/LO registers. The `hi` and `lo` outputs feed directly into the 32-bit 2:1 result mux that implements MFHI/MFLO, which makes this block the immediate upstream producer for that mux. The engine is radix-2: one iteration per clock, with a start/busy/done handshake toward the control unit.

---
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Radix-2 multi-cycle multiply/divide unit holding the HI/LO registers.
// Ports: clk, rst, start/op/operand_a/operand_b in; busy, done, hi, lo, div_by_zero out.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, mb, ar;
  logic             is_div, neg_q, neg_r, bz;

  logic             accept, last;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH:0]   sum, shl;
  logic [WIDTH-1:0] acc_n, q_n;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, hi_n, lo_n;

  assign busy   = (state == RUN);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // op[0] marks the signed variants
  always_comb begin
    sa    = op[0] & operand_a[WIDTH-1];
    sb    = op[0] & operand_b[WIDTH-1];
    abs_a = sa ? -operand_a : operand_a;
    abs_b = sb ? -operand_b : operand_b;
  end

  // One iteration. Multiply: {acc,q} is the product register, q holds the
  // not-yet-consumed multiplier bits. Divide: acc is the partial remainder,
  // q shifts dividend bits out and quotient bits in.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, mb};
    shl   = {acc, q[WIDTH-1]};
    acc_n = acc;
    q_n   = q;
    if (is_div) begin
      if (shl >= {1'b0, mb}) begin
        acc_n = WIDTH'(shl - {1'b0, mb});
        q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shl[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      {acc_n, q_n} = {sum, q[WIDTH-1:1]};
    end else begin
      {acc_n, q_n} = {1'b0, acc, q[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the final iteration's values
  always_comb begin
    prod = {acc_n, q_n};
    if (neg_q) prod = -prod;
    quo  = neg_q ? -q_n : q_n;
    rem  = neg_r ? -acc_n : acc_n;
    if (!is_div) begin
      {hi_n, lo_n} = prod;
    end else if (bz) begin
      hi_n = ar;
      lo_n = '1;
    end else begin
      hi_n = rem;
      lo_n = quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      mb          <= '0;
      ar          <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      bz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= last;
      div_by_zero <= last & is_div & bz;
      if (accept) begin
        cnt    <= '0;
        acc    <= '0;
        q      <= abs_a;
        mb     <= abs_b;
        ar     <= operand_a;
        is_div <= op[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        bz     <= (operand_b == '0);
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        acc <= acc_n;
        q   <= q_n;
        if (last) begin
          hi <= hi_n;
          lo <= lo_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Ops are queued at issue and checked when done pulses.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          t0;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_seen = 0;

  logic        sel;
  logic [31:0] mux_out;
  assign mux_out = sel ? hi : lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_seen++;
      chk("busy_done_excl", 64'(busy), 64'(0));
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk({e.tag, ".hi"}, 64'(hi), 64'(e.hi));
        chk({e.tag, ".lo"}, 64'(lo), 64'(e.lo));
        chk({e.tag, ".dbz"}, 64'(div_by_zero), 64'(e.dbz));
        chk({e.tag, ".lat"}, 64'(cyc - e.t0), 64'(32));
      end
    end
  end

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] a, b);
    exp_t e;
    logic signed [63:0] p;
    logic signed [31:0] sa, sbv;
    sa    = a;
    sbv   = b;
    e.dbz = 1'b0;
    e.t0  = 0;
    e.tag = "rnd";
    case (o)
      2'd0: {e.hi, e.lo} = {32'd0, a} * {32'd0, b};
      2'd1: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {e.hi, e.lo} = p;
      end
      default: begin
        if (b == 32'd0) begin
          e.hi  = a;
          e.lo  = 32'hFFFF_FFFF;
          e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          e.hi = a % b;
          e.lo = a / b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = 32'd0;
          e.lo = 32'h8000_0000;
        end else begin
          e.hi = sa % sbv;
          e.lo = sa / sbv;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input string tag, input logic [1:0] o,
                       input logic [31:0] a, b, input logic [31:0] eh, el,
                       input logic ed, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, ".issue_wait"}, 64'(1), 64'(0));
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.dbz = ed;
      e.t0  = cyc;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    exp_t m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          d0;
    rst       = 1'b1;
    start     = 1'b0;
    op        = 2'd0;
    operand_a = '0;
    operand_b = '0;
    sel       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.hi", 64'(hi), 64'(0));
    chk("rst.lo", 64'(lo), 64'(0));
    chk("rst.dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;

    issue("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    wait_idle();

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.hi", 64'(hi), 64'(0));
    chk("arst.lo", 64'(lo), 64'(0));
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    issue("mult", 2'd1, 32'hFFFF_FFFA, 32'd7,
          32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 1);
    wait_idle();
    sel = 1'b1;
    #1 chk("mux.hi", 64'(mux_out), 64'hFFFF_FFFF);
    sel = 1'b0;
    #1 chk("mux.lo", 64'(mux_out), 64'hFFFF_FFD6);

    issue("div", 2'd3, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
    repeat (5) @(negedge clk);
    chk("hold.hi", 64'(hi), 64'hFFFF_FFFF);
    chk("hold.lo", 64'(lo), 64'hFFFF_FFD6);
    issue("divu", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    issue("divu0", 2'd2, 32'h1234_5678, 32'd0,
          32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
    issue("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0, 1);
    wait_idle();

    issue("ign", 2'd0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1);
    repeat (4) @(negedge clk);
    op        = 2'd0;
    operand_a = 32'd3;
    operand_b = 32'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue("b2b", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      if (i[0]) rb = rb >> $urandom_range(0, 31);
      m = model(ro, ra, rb);
      issue($sformatf("rnd%0d", i), ro, ra, rb, m.hi, m.lo, m.dbz, 1);
    end
    wait_idle();

    d0 = done_seen;
    issue("abort", 2'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.hi", 64'(hi), 64'(0));
    chk("abort.lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort.no_done", 64'(done_seen - d0), 64'(0));
    chk("abort.idle", 64'(busy), 64'(0));
    chk("sb.empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
